alub_operand_stage: RTL and testbench
=====================================

# alub_operand_stage

Parametrised ALU operand-B stage for the multicycle datapath, the successor to the fixed 4-way operand-B mux. Forms operand B from the rt register value or the instruction immediate in one of six modes, then buffers it in a two-entry skid stage with valid/ready handshakes on both sides. The ALU can stall without losing an operand, and the control unit can flush the stage on a branch or exception.

## Interface
- DATA_W, 32, operand width; must satisfy DATA_W ≥ IMM_W + SHIFT.
- IMM_W, 16, immediate field width.
- CONST_VAL, 4, constant operand (PC increment); truncated to DATA_W.
- SHIFT, 2, left-shift amount for the SE-shifted mode.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- flush  in  1  synchronous discard of all buffered operands.
- in_valid  in  1  upstream offers an operand request.
- in_ready  out  1  stage can accept a request this cycle.
- src_sel  in  3  operand mode (encoding under Operation).
- rt_data  in  DATA_W  register-file rt value.
- imm  in  IMM_W  instruction immediate.
- out_valid  out  1  out_data holds a valid operand.
- out_ready  in  1  ALU consumes the operand this cycle.
- out_data  out  DATA_W  operand B.
- out_sel  out  3  src_sel that produced out_data (debug/trace tag).
- bad_sel  out  1  sticky flag: a reserved src_sel was accepted.

## Operation
Handshake terms:
- accept = in_valid & in_ready.
- pop = out_valid & out_ready.

Operand formation (combinational, evaluated at accept):
- 000 → rt_data.
- 001 → CONST_VAL.
- 010 → sign-extended imm; the MSB is replicated into the upper DATA_W−IMM_W bits.
- 011 → (sign-extended imm) << SHIFT; bits shifted past DATA_W−1 are dropped.
- 100 → zero-extended imm.
- 101 → imm << (DATA_W−IMM_W), i.e. LUI form with zero low bits.
- 110, 111 → operand 0; bad_sel set to 1 and held until reset. flush does not clear it.

Buffer FSM. States are EMPTY, ONE and TWO. Main register M drives the outputs; skid register S holds a second entry.
- EMPTY: accept → ONE, M ← new.
- ONE: accept & !pop → TWO, S ← new. accept & pop → ONE, M ← new. pop only → EMPTY. Otherwise hold.
- TWO: no accept possible. pop → ONE, M ← S. Otherwise hold.

Outputs:
- in_ready = (state != TWO); derived from registered state only, with no combinational path from out_ready.
- out_valid = (state != EMPTY).

Flush:
- Next state is EMPTY regardless of accept or pop in the same cycle.
- Any request accepted in the flush cycle is dropped.

Data integrity:
- While out_valid & !out_ready, out_data and out_sel hold stable.
- Operands leave in accept order.

## Timing
- Reset values: state EMPTY, out_valid 0, in_ready 1, out_data 0, out_sel 000, bad_sel 0.
- Latency: an operand accepted at edge N appears on out_data with out_valid=1 after edge N, when the stage was EMPTY.
- Throughput: one operand per cycle while out_ready stays high.
- After out_ready deasserts, in_ready falls one cycle after the second entry is taken.
- Reset or flush in any state: EMPTY after the edge. Data registers are not required to clear on flush, but out_valid must be 0.
- Simultaneous reset and flush: reset wins; bad_sel is also cleared.
- bad_sel rises on the edge that accepts the reserved code.

## Structure
- Shared package alub_pkg holds:
  - the six src_sel localparams (SEL_RT, SEL_CONST, SEL_SE, SEL_SE_SHL, SEL_ZE, SEL_LUI);
  - the state encoding (ST_EMPTY, ST_ONE, ST_TWO).
- Sub-module alub_operand_gen: purely combinational operand formation, parametrised by DATA_W, IMM_W, CONST_VAL and SHIFT.
- Top level holds the FSM, the M/S registers and the bad_sel flag.
- Target size: about 150–250 lines of RTL in total.

## Test plan
- Mode sweep: out_ready=1, imm=16'h8003, rt_data=32'h12345678, src_sel 000..101 on consecutive cycles. Required out_data sequence: 12345678, 00000004, FFFF8003, FFFE000C, 00008003, 80030000, each one cycle after accept.
- Stall: hold out_ready=0 and offer three requests (A, B, C).
  - A and B are accepted.
  - in_ready=0 from the cycle after B is accepted; C is held.
  - out_data stays at A.
  - After out_ready=1, A, B and C emerge in order.
- Simultaneous accept and pop in state ONE: the state remains ONE and out_data updates every cycle with no bubble over 8 back-to-back operands.
- Flush in state TWO while in_valid=1: the next cycle shows out_valid=0 and in_ready=1, and the flushed-cycle input never appears.
- Reserved code 110 accepted: out_data=0 and bad_sel=1. bad_sel persists through flush and clears only on reset.
- Reset mid-stream, asserted in state TWO: after the edge out_valid=0, in_ready=1, out_sel=000; the next accept behaves as from EMPTY.

Source files
------------

// File: rtl/alub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alub_pkg
// Description : Shared constants for the ALU operand-B stage: operand mode
//               encodings and buffer state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package alub_pkg;

    // Operand-B source modes (src_sel encoding); 110 and 111 are reserved
    localparam logic [2:0] SEL_RT     = 3'b000;
    localparam logic [2:0] SEL_CONST  = 3'b001;
    localparam logic [2:0] SEL_SE     = 3'b010;
    localparam logic [2:0] SEL_SE_SHL = 3'b011;
    localparam logic [2:0] SEL_ZE     = 3'b100;
    localparam logic [2:0] SEL_LUI    = 3'b101;

    // Skid-buffer occupancy states
    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_ONE     = 2'd1;
    localparam logic [1:0] ST_TWO     = 2'd2;

endpackage : alub_pkg
`default_nettype wire

// File: rtl/alub_operand_gen.sv
`default_nettype none
// ============================================================================
// Module      : alub_operand_gen
// Description : Combinational operand-B formation from the rt register value
//               or the instruction immediate in one of six modes. Reserved
//               mode codes yield zero and raise the reserved flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alub_operand_gen
    import alub_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int IMM_W     = 16,
    parameter int CONST_VAL = 4,
    parameter int SHIFT     = 2
) (
    input  logic [2:0]        src_sel,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [IMM_W-1:0]  imm,
    output logic [DATA_W-1:0] operand,
    output logic              reserved
);

    localparam logic [DATA_W-1:0] c_CONST = DATA_W'(CONST_VAL);

    logic [DATA_W-1:0] w_se;
    logic [DATA_W-1:0] w_ze;

    // A sized cast of a signed value sign-extends; of an unsigned one, zero-extends
    assign w_se = DATA_W'($signed(imm));
    assign w_ze = DATA_W'(imm);

    // Mode decode; shifts drop bits pushed past the top of the operand
    always_comb begin
        operand  = '0;
        reserved = 1'b0;
        case (src_sel)
            SEL_RT:     operand = rt_data;
            SEL_CONST:  operand = c_CONST;
            SEL_SE:     operand = w_se;
            SEL_SE_SHL: operand = w_se << SHIFT;
            SEL_ZE:     operand = w_ze;
            SEL_LUI:    operand = w_ze << (DATA_W - IMM_W);
            default:    reserved = 1'b1;
        endcase
    end

endmodule : alub_operand_gen
`default_nettype wire

// File: rtl/alub_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : alub_operand_stage
// Description : ALU operand-B stage. Forms operand B and buffers it in a
//               two-entry skid stage (main register M drives the outputs,
//               skid register S holds a second entry) with valid/ready on
//               both sides, flush, and a sticky reserved-mode flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alub_operand_stage
    import alub_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int IMM_W     = 16,
    parameter int CONST_VAL = 4,
    parameter int SHIFT     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        src_sel,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [IMM_W-1:0]  imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_sel,
    output logic              bad_sel
);

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_m_data;
    logic [2:0]        r_m_sel;
    logic [DATA_W-1:0] r_s_data;
    logic [2:0]        r_s_sel;
    logic              r_bad_sel;

    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] w_operand;
    logic              w_reserved;
    logic              w_accept;
    logic              w_pop;
    logic              w_ld_m_new;
    logic              w_ld_m_skid;
    logic              w_ld_s;

    alub_operand_gen #(
        .DATA_W    (DATA_W),
        .IMM_W     (IMM_W),
        .CONST_VAL (CONST_VAL),
        .SHIFT     (SHIFT)
    ) u_gen (
        .src_sel  (src_sel),
        .rt_data  (rt_data),
        .imm      (imm),
        .operand  (w_operand),
        .reserved (w_reserved)
    );

    // Handshakes are derived from registered state only, so in_ready has no
    // combinational path from out_ready
    assign in_ready  = (r_state != ST_TWO);
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_m_data;
    assign out_sel   = r_m_sel;
    assign bad_sel   = r_bad_sel;

    assign w_accept  = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Next-state and register-load decode; flush empties the stage and drops
    // anything accepted in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        w_ld_m_new  = 1'b0;
        w_ld_m_skid = 1'b0;
        w_ld_s      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_ONE;
                    w_ld_m_new  = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_pop) begin
                    w_ld_m_new  = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = ST_TWO;
                    w_ld_s      = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_pop) begin
                    w_state_nxt = ST_ONE;
                    w_ld_m_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_ld_m_new  = 1'b0;
            w_ld_m_skid = 1'b0;
            w_ld_s      = 1'b0;
        end
    end

    // State, M/S registers and sticky reserved flag; reset beats flush
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_EMPTY;
            r_m_data  <= '0;
            r_m_sel   <= '0;
            r_s_data  <= '0;
            r_s_sel   <= '0;
            r_bad_sel <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ld_m_new) begin
                r_m_data <= w_operand;
                r_m_sel  <= src_sel;
            end else if (w_ld_m_skid) begin
                r_m_data <= r_s_data;
                r_m_sel  <= r_s_sel;
            end
            if (w_ld_s) begin
                r_s_data <= w_operand;
                r_s_sel  <= src_sel;
            end
            // A request dropped by flush does not count as accepted
            if (w_accept && w_reserved && !flush) begin
                r_bad_sel <= 1'b1;
            end
        end
    end

endmodule : alub_operand_stage
`default_nettype wire

// File: tb/tb_alub_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alub_operand_stage
// Description : Directed self-checking bench for alub_operand_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alub_operand_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  src_sel;
    logic [31:0] rt_data;
    logic [15:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_sel;
    logic        bad_sel;

    int n_cmp = 0;
    int n_err = 0;

    alub_operand_stage #(
        .DATA_W    (32),
        .IMM_W     (16),
        .CONST_VAL (4),
        .SHIFT     (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src_sel   (src_sel),
        .rt_data   (rt_data),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .bad_sel   (bad_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [31:0] sweep_exp [6];

    initial begin
        sweep_exp[0] = 32'h12345678;
        sweep_exp[1] = 32'h00000004;
        sweep_exp[2] = 32'hFFFF8003;
        sweep_exp[3] = 32'hFFFE000C;
        sweep_exp[4] = 32'h00008003;
        sweep_exp[5] = 32'h80030000;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        src_sel = 3'b000; rt_data = '0; imm = '0;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_out_sel",   32'(out_sel),   32'd0);
        chk("rst_bad_sel",   32'(bad_sel),   32'd0);
        reset = 1'b0;

        // Mode sweep: one operand per cycle, each visible right after accept
        out_ready = 1'b1; imm = 16'h8003; rt_data = 32'h12345678;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; src_sel = 3'(i);
            tick();
            chk($sformatf("sweep_data_%0d", i), out_data, sweep_exp[i]);
            chk($sformatf("sweep_sel_%0d", i), 32'(out_sel), 32'(i));
            chk($sformatf("sweep_valid_%0d", i), 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("sweep_drain_valid", 32'(out_valid), 32'd0);

        // Stall: A and B accepted, C held off until the ALU drains
        out_ready = 1'b0; src_sel = 3'b000;
        in_valid = 1'b1; rt_data = 32'hAAAA0001;
        tick();
        chk("stall_a_data",  out_data,      32'hAAAA0001);
        chk("stall_a_ready", 32'(in_ready), 32'd1);
        rt_data = 32'hBBBB0002;
        tick();
        chk("stall_b_ready", 32'(in_ready), 32'd0);
        chk("stall_b_data",  out_data,      32'hAAAA0001);
        rt_data = 32'hCCCC0003;
        tick();
        chk("stall_c_ready", 32'(in_ready), 32'd0);
        chk("stall_c_data",  out_data,      32'hAAAA0001);
        chk("stall_c_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("drain_b_data",  out_data,      32'hBBBB0002);
        chk("drain_b_ready", 32'(in_ready), 32'd1);
        tick();
        chk("drain_c_data",  out_data,      32'hCCCC0003);
        in_valid = 1'b0;
        tick();
        chk("drain_empty",   32'(out_valid), 32'd0);

        // Back-to-back accept and pop with no bubble
        in_valid = 1'b1; src_sel = 3'b000;
        for (int k = 0; k < 8; k++) begin
            rt_data = 32'h0000_0100 + 32'(k);
            tick();
            chk($sformatf("b2b_data_%0d", k), out_data, 32'h0000_0100 + 32'(k));
            chk($sformatf("b2b_valid_%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("b2b_ready_%0d", k), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();

        // Flush in TWO with in_valid high
        out_ready = 1'b0; in_valid = 1'b1;
        rt_data = 32'h1111_0001; tick();
        rt_data = 32'h2222_0002; tick();
        chk("fl_two_ready", 32'(in_ready), 32'd0);
        flush = 1'b1; rt_data = 32'h3333_0003;
        tick();
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ready", 32'(in_ready),  32'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("fl_after_valid", 32'(out_valid), 32'd0);

        // Flush in ONE while a request is accepted: that request is dropped
        in_valid = 1'b1; out_ready = 1'b0; rt_data = 32'h4444_0004;
        tick();
        chk("fl1_setup_valid", 32'(out_valid), 32'd1);
        flush = 1'b1; rt_data = 32'h5555_0005;
        tick();
        chk("fl1_valid", 32'(out_valid), 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("fl1_after_valid", 32'(out_valid), 32'd0);

        // Reserved code: zero operand, sticky flag survives flush
        out_ready = 1'b1; in_valid = 1'b1; src_sel = 3'b110; rt_data = 32'hDEADBEEF;
        tick();
        chk("rsv_data",  out_data,       32'd0);
        chk("rsv_sel",   32'(out_sel),   32'd6);
        chk("rsv_bad",   32'(bad_sel),   32'd1);
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("rsv_bad_after_flush", 32'(bad_sel), 32'd1);
        chk("rsv_flush_valid",     32'(out_valid), 32'd0);
        tick();
        chk("rsv_bad_hold", 32'(bad_sel), 32'd1);
        reset = 1'b1; flush = 1'b1;
        tick();
        reset = 1'b0; flush = 1'b0;
        chk("rsv_bad_cleared", 32'(bad_sel), 32'd0);

        // Reset asserted in TWO, then restart as from EMPTY
        out_ready = 1'b0; in_valid = 1'b1; src_sel = 3'b001;
        tick();
        chk("rt_p_data", out_data, 32'h0000_0004);
        src_sel = 3'b010;
        tick();
        chk("rt_two_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rt_valid", 32'(out_valid), 32'd0);
        chk("rt_ready", 32'(in_ready),  32'd1);
        chk("rt_sel",   32'(out_sel),   32'd0);
        in_valid = 1'b1; src_sel = 3'b100; imm = 16'h8003;
        tick();
        in_valid = 1'b0;
        chk("rt_restart_data",  out_data,       32'h0000_8003);
        chk("rt_restart_valid", 32'(out_valid), 32'd1);
        chk("rt_restart_sel",   32'(out_sel),   32'd4);
        tick();
        chk("rt_restart_ready", 32'(in_ready),  32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_alub_operand_stage
`default_nettype wire
